fnd_scan_drv: RTL

//  Display stage downstream of the 0..59 seconds counter. Samples the 6-bit count,

---
 rtl/fnd_pkg.sv | 44 ++++
 rtl/fnd_scan_drv_if.sv | 12 +
 rtl/fnd_scan_drv_bin2bcd_seq.sv | 85 ++++++++
 rtl/fnd_scan_drv.sv | 113 +++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared types and 7-segment constants for the seconds display stage.
// Conversion FSM states and digit decode live here so both levels agree.
package fnd_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SUB  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_OFF = 7'h00;

  function automatic logic [6:0] seg_dec(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0:    s = SEG_0;
      4'h1:    s = SEG_1;
      4'h2:    s = SEG_2;
      4'h3:    s = SEG_3;
      4'h4:    s = SEG_4;
      4'h5:    s = SEG_5;
      4'h6:    s = SEG_6;
      4'h7:    s = SEG_7;
      4'h8:    s = SEG_8;
      4'h9:    s = SEG_9;
      4'hE:    s = SEG_E;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/fnd_scan_drv_if.sv
// Bundle between the upstream seconds counter / display and the scan driver.
interface fnd_scan_drv_if;
  logic [5:0] in_val;
  logic [6:0] seg;
  logic [1:0] com;
  logic [7:0] bcd;
  logic       busy;
  logic       err;

  modport master (output in_val, input seg, com, bcd, busy, err);
  modport slave  (input in_val, output seg, com, bcd, busy, err);
endinterface

// File: rtl/fnd_scan_drv_bin2bcd_seq.sv
// Sequential 6-bit binary to 2-digit BCD converter (repeated subtract-10).
// Both digits are committed together in DONE, so a partial result is never visible.
module bin2bcd_seq
  import fnd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] bin,
  output logic       busy,
  output logic       done,
  output logic [7:0] bcd,
  output logic       err
);

  state_t     state_q;
  logic [5:0] acc_q;
  logic [5:0] rem_q;
  logic [3:0] tens_q;
  logic       busy_q;
  logic       done_q;
  logic [7:0] bcd_q;
  logic       err_q;

  // Conversion FSM with registered status and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= 6'd0;
      rem_q   <= 6'd0;
      tens_q  <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            acc_q   <= bin;
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          rem_q   <= acc_q;
          tens_q  <= 4'd0;
          state_q <= S_SUB;
        end
        S_SUB: begin
          if (rem_q >= 6'd10) begin
            rem_q  <= rem_q - 6'd10;
            tens_q <= tens_q + 4'd1;
          end else begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          // Out-of-range counts still run the FSM but display "EE"
          if (acc_q > 6'd59) begin
            bcd_q <= 8'hEE;
            err_q <= 1'b1;
          end else begin
            bcd_q <= {tens_q, rem_q[3:0]};
            err_q <= 1'b0;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign err  = err_q;

endmodule

// File: rtl/fnd_scan_drv.sv
// 2-digit multiplexed 7-segment driver for the 0..59 seconds count.
// Filters the slow-domain count for stability, converts it, and scans the digits.
module fnd_scan_drv
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic           clk,
  input  logic           rst,
  fnd_scan_drv_if.slave  bus
);

  localparam int             CW      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(SCAN_DIV - 1);

  logic [5:0]    s1_q;
  logic          stable_q;
  logic [5:0]    acc_q;
  logic [5:0]    last_acc_q;
  logic          accept;

  logic          conv_busy;
  logic          conv_done;
  logic [7:0]    conv_bcd;
  logic          conv_err;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          slot_q, slot_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    com_q, com_d;

  // The input must match the previous sample on two consecutive cycles; done also
  // blocks acceptance for the one cycle before last_acc catches up.
  assign accept = stable_q && (s1_q == bus.in_val) && (s1_q != last_acc_q)
                  && !conv_busy && !conv_done;

  // Input stability filter and record of the last value handed to the converter
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= 6'd0;
      stable_q   <= 1'b0;
      acc_q      <= 6'd0;
      last_acc_q <= 6'd0;
    end else begin
      s1_q     <= bus.in_val;
      stable_q <= (s1_q == bus.in_val);
      if (accept) begin
        acc_q <= s1_q;
      end
      if (conv_done) begin
        last_acc_q <= acc_q;
      end
    end
  end

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (accept),
    .bin   (s1_q),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .err   (conv_err)
  );

  // Next scan position and the segment pattern for the slot that will be active
  always_comb begin
    cnt_d  = cnt_q;
    slot_d = slot_q;
    seg_d  = SEG_OFF;
    com_d  = 2'b10;
    if (cnt_q == CNT_MAX) begin
      cnt_d  = '0;
      slot_d = ~slot_q;
    end else begin
      cnt_d  = cnt_q + CW'(1);
    end
    if (slot_d) begin
      com_d = 2'b01;
      if ((conv_bcd[7:4] == 4'd0) && !conv_err) begin
        seg_d = SEG_OFF;
      end else begin
        seg_d = seg_dec(conv_bcd[7:4]);
      end
    end else begin
      com_d = 2'b10;
      seg_d = seg_dec(conv_bcd[3:0]);
    end
  end

  // seg and com share one register stage so slot changes never ghost
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      slot_q <= 1'b0;
      seg_q  <= SEG_0;
      com_q  <= 2'b10;
    end else begin
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
      seg_q  <= seg_d;
      com_q  <= com_d;
    end
  end

  assign bus.seg  = seg_q;
  assign bus.com  = com_q;
  assign bus.bcd  = conv_bcd;
  assign bus.busy = conv_busy;
  assign bus.err  = conv_err;

endmodule
